// File: rtl/instruction_queue_if.sv
// Handshake and decoded-field bundle between fetch, the instruction queue and decode.
// The queue itself connects through the slave modport.
interface instruction_queue_if #(
    parameter int INSTR_WIDTH  = 32,
    parameter int OPCODE_WIDTH = 6,
    parameter int REG_WIDTH    = 5,
    parameter int IMM_WIDTH    = 16,
    parameter int COUNT_WIDTH  = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [INSTR_WIDTH-1:0]  Instr_in;
    logic                    out_valid;
    logic                    out_ready;
    logic                    flush;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [REG_WIDTH-1:0]    R1;
    logic [REG_WIDTH-1:0]    R2;
    logic [REG_WIDTH-1:0]    R3;
    logic [IMM_WIDTH-1:0]    Immediate;
    logic [INSTR_WIDTH-1:0]  Imm_sext;
    logic [INSTR_WIDTH-1:0]  Instr_out;
    logic [COUNT_WIDTH-1:0]  count;

    modport master (
        output in_valid, Instr_in, out_ready, flush,
        input  in_ready, out_valid, opcode, R1, R2, R3, Immediate, Imm_sext, Instr_out, count
    );

    modport slave (
        input  in_valid, Instr_in, out_ready, flush,
        output in_ready, out_valid, opcode, R1, R2, R3, Immediate, Imm_sext, Instr_out, count
    );
endinterface

// File: rtl/instruction_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode with one-cycle flush and
// field decode of the head word.
module instruction_queue #(
    parameter int INSTR_WIDTH  = 32,
    parameter int DEPTH        = 4,
    parameter int OPCODE_WIDTH = 6,
    parameter int REG_WIDTH    = 5,
    parameter int IMM_WIDTH    = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    instruction_queue_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int R1_MSB = INSTR_WIDTH - OPCODE_WIDTH - 1;
    localparam int R2_MSB = R1_MSB - REG_WIDTH;
    localparam int R3_MSB = R2_MSB - REG_WIDTH;

    logic [INSTR_WIDTH-1:0] storage_reg [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic                   push_fire;
    logic                   pop_fire;
    logic [INSTR_WIDTH-1:0] head;

    // Handshake flags come only from registered occupancy, so a pop never frees a slot
    // for a push in the same cycle.
    assign bus.in_ready  = (count_reg != CNT_W'(DEPTH));
    assign bus.out_valid = (count_reg != '0);
    assign bus.count     = count_reg;

    assign push_fire = bus.in_valid && bus.in_ready;
    assign pop_fire  = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (bus.flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_fire) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop_fire)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            if (push_fire && !pop_fire)      count_next = count_reg + CNT_W'(1);
            else if (pop_fire && !push_fire) count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is zeroed on reset so the decoded outputs read 0 while held in reset;
    // flush only rewinds the pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) storage_reg[i] <= '0;
        end else if (push_fire && !bus.flush) begin
            storage_reg[wr_ptr_reg] <= bus.Instr_in;
        end
    end

    assign head          = storage_reg[rd_ptr_reg];
    assign bus.Instr_out = head;
    assign bus.opcode    = head[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign bus.R1        = head[R1_MSB -: REG_WIDTH];
    assign bus.R2        = head[R2_MSB -: REG_WIDTH];
    assign bus.R3        = head[R3_MSB -: REG_WIDTH];
    assign bus.Immediate = head[IMM_WIDTH-1:0];
    assign bus.Imm_sext  = {{(INSTR_WIDTH-IMM_WIDTH){head[IMM_WIDTH-1]}}, head[IMM_WIDTH-1:0]};
endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: directed scenarios plus random traffic, every cycle checked
// against a queue-based reference model.
module tb_instruction_queue;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int OPW   = 6;
    localparam int RW    = 5;
    localparam int IMMW  = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    instruction_queue_if #(.INSTR_WIDTH(W), .OPCODE_WIDTH(OPW), .REG_WIDTH(RW),
                           .IMM_WIDTH(IMMW), .COUNT_WIDTH(CW)) bus ();

    instruction_queue #(.INSTR_WIDTH(W), .DEPTH(DEPTH), .OPCODE_WIDTH(OPW),
                        .REG_WIDTH(RW), .IMM_WIDTH(IMMW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words with the handshake rules applied at each edge.
    logic [W-1:0] q[$];
    bit           m_push, m_pop;

    always @(posedge clock) begin
        if (reset_n) begin
            if (bus.flush) begin
                if (q.size() > 0 || bus.in_valid) $display("flush drop=%0d", q.size());
                q.delete();
            end else begin
                m_pop  = bus.out_ready && (q.size() > 0);
                m_push = bus.in_valid && (q.size() < DEPTH);
                if (m_pop) begin
                    $display("pop  %08h", q[0]);
                    void'(q.pop_front());
                end
                if (m_push) begin
                    $display("push %08h", bus.Instr_in);
                    q.push_back(bus.Instr_in);
                end
            end
        end
    end

    always @(negedge reset_n) q.delete();

    logic [W-1:0] mh;
    logic [W-1:0] msext;
    longint       mimm;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_count", 64'(bus.count), 64'd0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_instr_out", 64'(bus.Instr_out), 64'd0);
            chk("rst_imm_sext", 64'(bus.Imm_sext), 64'd0);
        end else begin
            chk("count", 64'(bus.count), 64'(q.size()));
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                mh   = q[0];
                mimm = longint'(mh) % (64'd1 << IMMW);
                if (mimm >= (64'd1 << (IMMW - 1))) mimm = mimm - (64'd1 << IMMW);
                msext = W'(mimm);
                chk("instr_out", 64'(bus.Instr_out), 64'(mh));
                chk("opcode", 64'(bus.opcode), 64'(mh / (1 << (W - OPW))));
                chk("r1", 64'(bus.R1), 64'((mh / (1 << (W - OPW - RW))) % (1 << RW)));
                chk("r2", 64'(bus.R2), 64'((mh / (1 << (W - OPW - 2 * RW))) % (1 << RW)));
                chk("r3", 64'(bus.R3), 64'((mh / (1 << (W - OPW - 3 * RW))) % (1 << RW)));
                chk("immediate", 64'(bus.Immediate), 64'(mh % (1 << IMMW)));
                chk("imm_sext", 64'(bus.Imm_sext), 64'(msext));
            end
        end
    end

    task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        bus.in_valid  = v;
        bus.Instr_in  = d;
        bus.out_ready = r;
        bus.flush     = f;
        @(negedge clock);
    endtask

    logic [W-1:0] words [5];

    initial begin
        bus.in_valid = 1'b0; bus.Instr_in = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);

        // Push and decode
        step(1, 32'h8C22_FFFC, 0, 0);
        chk("dec_valid", 64'(bus.out_valid), 64'd1);
        chk("dec_opcode", 64'(bus.opcode), 64'h23);
        chk("dec_r1", 64'(bus.R1), 64'd1);
        chk("dec_r2", 64'(bus.R2), 64'd2);
        chk("dec_r3", 64'(bus.R3), 64'h1F);
        chk("dec_imm", 64'(bus.Immediate), 64'hFFFC);
        chk("dec_sext", 64'(bus.Imm_sext), 64'hFFFF_FFFC);
        step(0, 0, 1, 0);

        // Sign extension
        step(1, 32'h0000_7FFF, 0, 0);
        chk("sext_pos", 64'(bus.Imm_sext), 64'h0000_7FFF);
        step(1, 32'h1234_8000, 1, 0);
        chk("sext_neg", 64'(bus.Imm_sext), 64'hFFFF_8000);
        step(0, 0, 1, 0);

        // Fill and backpressure
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        for (int i = 0; i < 4; i++) step(1, words[i], 0, 0);
        chk("full_count", 64'(bus.count), 64'd4);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        step(1, words[4], 0, 0);
        chk("held_count", 64'(bus.count), 64'd4);
        step(1, words[4], 1, 0);
        chk("after_pop_count", 64'(bus.count), 64'd3);
        chk("after_pop_ready", 64'(bus.in_ready), 64'd1);
        step(1, words[4], 0, 0);
        chk("refill_count", 64'(bus.count), 64'd4);
        for (int i = 1; i < 5; i++) begin
            chk("fill_order", 64'(bus.Instr_out), 64'(words[i]));
            step(0, 0, 1, 0);
        end
        chk("drained_valid", 64'(bus.out_valid), 64'd0);

        // Concurrent push and pop across pointer wrap
        step(1, $urandom, 0, 0);
        step(1, $urandom, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, $urandom, 1, 0);
            chk("concurrent_count", 64'(bus.count), 64'd2);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Flush beats push and pop
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
        step(1, 32'hDEAD_BEEF, 1, 1);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        step(1, 32'h1111_1111, 0, 0);
        chk("post_flush_head", 64'(bus.Instr_out), 64'h1111_1111);
        step(0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 32) == 0);

        // Asynchronous reset mid-stream with three entries queued
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
        chk("pre_reset_count", 64'(bus.count), 64'd3);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(bus.count), 64'd0);
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_ready", 64'(bus.in_ready), 64'd1);
        chk("async_rst_opcode", 64'(bus.opcode), 64'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        step(1, 32'hA5A5_0001, 0, 0);
        chk("first_push_after_rst", 64'(bus.Instr_out), 64'hA5A5_0001);
        chk("first_push_count", 64'(bus.count), 64'd1);
        step(0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_queue.md
# instruction_queue

Parametrised successor to the single-entry instruction register: a DEPTH-entry FIFO of fetched instruction words with valid/ready handshakes on both sides, a flush input, and field-decoded outputs (opcode, three register specifiers, raw and sign-extended immediate) taken from the head entry. It sits between instruction fetch and the decode/control unit. Fetch can run ahead of decode, and a taken branch or jump discards queued words in one cycle.

## Interface
Parameters:
- INSTR_WIDTH, 32: instruction word width.
- DEPTH, 4: number of entries. Must be a power of two, ≥2.
- OPCODE_WIDTH, 6: opcode field width.
- REG_WIDTH, 5: register-specifier field width.
- IMM_WIDTH, 16: immediate field width. Must be < INSTR_WIDTH.

Ports:
- clock  in  1  rising-edge clock. Single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents a word on Instr_in.
- in_ready  out  1  queue can accept a word (= !full).
- Instr_in  in  INSTR_WIDTH  instruction word from fetch.
- out_valid  out  1  head entry is valid (= !empty).
- out_ready  in  1  decode consumes the head this cycle.
- flush  in  1  discard all entries.
- opcode  out  OPCODE_WIDTH  head[INSTR_WIDTH-1 -: OPCODE_WIDTH].
- R1  out  REG_WIDTH  next REG_WIDTH bits below opcode.
- R2  out  REG_WIDTH  next REG_WIDTH bits below R1.
- R3  out  REG_WIDTH  next REG_WIDTH bits below R2.
- Immediate  out  IMM_WIDTH  head[IMM_WIDTH-1:0].
- Imm_sext  out  INSTR_WIDTH  Immediate sign-extended from bit IMM_WIDTH-1.
- Instr_out  out  INSTR_WIDTH  full head word.
- count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

## Operation
- Push fires when in_valid && in_ready. Instr_in is written at wr_ptr, then wr_ptr increments.
- Pop fires when out_valid && out_ready. rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. count tracks occupancy. full = (count==DEPTH). empty = (count==0).
- Simultaneous push and pop when 0<count<DEPTH: both happen and count is unchanged.
- When full, in_ready=0. A same-cycle pop does not enable a push (no pass-through). in_ready rises the cycle after the pop.
- When empty, out_valid=0 and no bypass. A pushed word becomes visible at the head one cycle later.
- flush has priority over push and pop. Pointers and count go to 0. A same-cycle in_valid word is dropped, and a same-cycle out_ready does nothing. Storage contents are not cleared.
- Decoded fields are combinational slices of storage[rd_ptr]. They are meaningful only while out_valid=1. Field bit positions are fixed by the parameters. With defaults: opcode=[31:26], R1=[25:21], R2=[20:16], R3=[15:11], Immediate=[15:0]. R3 overlaps Immediate by design.
- Reset (reset_n=0, asynchronous): pointers=0, count=0, and all storage entries=0. Resulting output values: in_ready=1, out_valid=0, and all field outputs, Instr_out and Imm_sext are 0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push with in_ready=0 is ignored: no write and no error.
- Pop with out_valid=0 is ignored.

## Timing
- Push-to-head latency: 1 cycle when the queue is empty.
- Throughput: 1 push and 1 pop per cycle in the non-boundary state.
- in_ready, out_valid and count are pure functions of registered state. They do not depend combinationally on in_valid or out_ready.
- Field outputs change only after a clock edge or on reset assertion.
- Release of reset_n is synchronised externally. The first push is accepted on the first rising edge after release.

## Test plan
- Reset and empty: assert reset_n=0 mid-stream with count=3. Required response: count=0, out_valid=0, in_ready=1 and opcode=0 without waiting for a clock edge.
- Push and decode: push 0x8C22_FFFC into the empty queue. The next cycle requires out_valid=1, opcode=0x23, R1=1, R2=2, R3=0x1F, Immediate=0xFFFC, Imm_sext=0xFFFF_FFFC.
- Fill and backpressure: push 5 words with out_ready=0 at DEPTH=4. The first 4 are accepted, count=4, in_ready=0. The 5th word is held by the source, then accepted the cycle after one pop. Pop order must match push order.
- Concurrent push and pop: with count=2, hold in_valid=out_ready=1 for 10 cycles. count must stay 2, the pointers must wrap correctly, and the popped sequence must equal the pushed sequence.
- Flush: with count=3, assert flush together with in_valid=1 and out_ready=1. The next cycle requires count=0 and out_valid=0. The word presented with flush must never appear at the head.
- Sign extension: push an immediate of 0x7FFF, then 0x8000. Required Imm_sext values: 0x0000_7FFF, then 0xFFFF_8000.
